// File: rtl/key_led_mode_ctrl_pkg.sv
// Shared mode/pattern definitions for the key-driven LED mode controller.
package key_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    localparam logic [1:0] PAT_ALL_OFF = 2'b00;
    localparam logic [1:0] PAT_ALL_ON  = 2'b11;
    localparam logic [1:0] PAT_ALT0    = 2'b01;
    localparam logic [1:0] PAT_ALT1    = 2'b10;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_OFF:   next_mode = MODE_ON;
            MODE_ON:    next_mode = MODE_BLINK;
            MODE_BLINK: next_mode = MODE_ALT;
            default:    next_mode = MODE_OFF;
        endcase
    endfunction

    // Logical (active-high) LED pattern for a mode and animation phase.
    function automatic logic [1:0] mode_pattern(input mode_e m, input logic phase);
        case (m)
            MODE_OFF:   mode_pattern = PAT_ALL_OFF;
            MODE_ON:    mode_pattern = PAT_ALL_ON;
            MODE_BLINK: mode_pattern = phase ? PAT_ALL_ON : PAT_ALL_OFF;
            default:    mode_pattern = phase ? PAT_ALT1 : PAT_ALT0;
        endcase
    endfunction

endpackage

// File: rtl/key_led_mode_ctrl_if.sv
// Board-side signal bundle: raw keys in, LED drive and status out.
interface key_led_mode_ctrl_if;
    logic [1:0] key;
    logic [1:0] led;
    logic [1:0] mode;
    logic       paused;

    modport master (output key, input led, input mode, input paused);
    modport slave  (input key, output led, output mode, output paused);
endinterface

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchroniser, stability counter, registered press pulse.
module key_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_stable,
    output logic press_pulse
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;

    always_comb begin
        sync_d   = {sync_q[0], key_in};
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        // Any cycle where the synced level agrees with the stable level restarts the count.
        if (sync_q[1] != stable_q) begin
            if (cnt_q == DEB_LAST) begin
                stable_d = sync_q[1];
                press_d  = stable_q & ~sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser and stable level power up "released" so a held key still debounces.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign key_stable  = stable_q;
    assign press_pulse = press_q;

endmodule

// File: rtl/key_led_mode_ctrl.sv
// Key-driven LED mode controller: key[0] cycles OFF/ON/BLINK/ALT, key[1] pauses animation.
// Define LED_ACTIVE_LOW_EN to drive the led pins inverted (lit = 0), including reset.
module key_led_mode_ctrl
    import key_led_pkg::*;
#(
    parameter int DEB_CNT  = 1_000_000,
    parameter int STEP_CNT = 25_000_000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    key_led_mode_ctrl_if.slave  io
);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [1:0] LED_POL = 2'b11;
`else
    localparam logic [1:0] LED_POL = 2'b00;
`endif

    localparam int SW = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CNT - 1);

    logic [1:0] press;
    logic [1:0] unused_key_stable;

    for (genvar i = 0; i < 2; i++) begin : g_deb
        key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .key_in      (io.key[i]),
            .key_stable  (unused_key_stable[i]),
            .press_pulse (press[i])
        );
    end

    mode_e         mode_q, mode_d;
    logic          paused_q, paused_d;
    logic          phase_q, phase_d;
    logic [SW-1:0] step_q, step_d;
    logic [1:0]    led_q, led_d;

    always_comb begin
        mode_d   = mode_q;
        paused_d = paused_q;
        phase_d  = phase_q;
        step_d   = step_q;

        if (press[1]) paused_d = ~paused_q;

        if (press[0]) begin
            mode_d  = next_mode(mode_q);
            step_d  = '0;
            phase_d = 1'b0;
        end else if (mode_q == MODE_BLINK || mode_q == MODE_ALT) begin
            if (!paused_q) begin
                if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    phase_d = ~phase_q;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
        end else begin
            step_d  = '0;
            phase_d = 1'b0;
        end

        // Frozen state (paused) implies a frozen pattern, so led needs no separate hold.
        led_d = mode_pattern(mode_d, phase_d) ^ LED_POL;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q   <= MODE_OFF;
            paused_q <= 1'b0;
            phase_q  <= 1'b0;
            step_q   <= '0;
            led_q    <= PAT_ALL_OFF ^ LED_POL;
        end else begin
            mode_q   <= mode_d;
            paused_q <= paused_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
            led_q    <= led_d;
        end
    end

    assign io.led    = led_q;
    assign io.mode   = mode_q;
    assign io.paused = paused_q;

endmodule
